// File: rtl/stage2_window_gen.sv
// Sliding KX x KY window generator feeding the stage-2 convolution kernel.
// Cascaded line buffers hold the previous KY-1 rows; a shift-register window is emitted per eligible pixel.
module stage2_window_gen #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int KX    = 5,
    parameter int KY    = 5,
    parameter int IBW   = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_clear,
    input  logic                   i_in_valid,
    input  logic [IBW-1:0]         i_in_pixel,
    output logic                   o_ot_valid,
    output logic [KX*KY*IBW-1:0]   o_ot_window,
    output logic                   o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ELIG = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_ELIG = RW'(KY - 1);

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [IBW-1:0] win_q [KY][KX];
    logic [IBW-1:0] win_d [KY][KX];
    logic [IBW-1:0] line_q [KY-1][IMG_W];
    logic [IBW-1:0] slice [KY];
    logic           accept;

    // A clear on the same cycle as a valid pixel drops that pixel.
    assign accept = i_in_valid && !i_clear;

    // Vertical slice at the current column: newest row at the bottom (row KY-1).
    always_comb begin
        slice[KY-1] = i_in_pixel;
        for (int k = 0; k < KY-1; k++) begin
            slice[KY-2-k] = line_q[k][col_q];
        end
    end

    // NOTE: every signal written here is given a default first so no latch is inferred.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        win_d   = win_q;

        if (i_clear) begin
            col_d = '0;
            row_d = '0;
        end else if (i_in_valid) begin
            valid_d = (row_q >= ROW_ELIG) && (col_q >= COL_ELIG);
            done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            for (int j = 0; j < KY; j++) begin
                for (int i = 0; i < KX-1; i++) begin
                    win_d[j][i] = win_q[j][i+1];
                end
                win_d[j][KX-1] = slice[j];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int j = 0; j < KY; j++) begin
                for (int i = 0; i < KX; i++) begin
                    win_q[j][i] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    // NOTE: line buffers are not reset; stale contents are masked by the eligibility rule.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[0][col_q] <= i_in_pixel;
            for (int k = 1; k < KY-1; k++) begin
                line_q[k][col_q] <= line_q[k-1][col_q];
            end
        end
    end

    // Pack in the kernel's i_in_fmap layout: element (j,i) at (j*KX+i)*IBW.
    always_comb begin
        o_ot_window = '0;
        for (int j = 0; j < KY; j++) begin
            for (int i = 0; i < KX; i++) begin
                o_ot_window[(j*KX+i)*IBW +: IBW] = win_q[j][i];
            end
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_frame_done = done_q;

endmodule
